// File: rtl/shift_taps_pkg.sv
// Shared definitions for the shift-register tap filter.
//   TAP_W / COEF_W / PROD_W / PAIR_W / SUM_W : datapath widths per pipeline stage
//   coef_t   : signed 9-bit tap weight
//   sat_u8() : clamps a signed stage-3 result into the unsigned 8-bit output range
package shift_taps_pkg;

  localparam int TAP_W  = 8;
  localparam int COEF_W = 9;
  localparam int PROD_W = 18;
  localparam int PAIR_W = 19;
  localparam int SUM_W  = 20;

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [PAIR_W-1:0] pair_t;
  typedef logic signed [SUM_W-1:0]  sum_t;

  function automatic logic [TAP_W-1:0] sat_u8(input sum_t v);
    logic [TAP_W-1:0] r;
    if (v < sum_t'(0))
      r = '0;
    else if (v > sum_t'(255))
      r = '1;
    else
      r = v[TAP_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/shift_taps_fifo.sv
// First-word-fall-through FIFO for filtered samples.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_flush        : synchronous clear of pointers and count
//   i_push, i_data : write request; accepted when not full, or when full and
//                    a pop happens in the same cycle
//   i_pop          : read request; ignored when empty
//   o_data/o_valid : head entry (zero while empty) and non-empty flag
//   o_full         : all DEPTH entries occupied
//   o_count        : current occupancy
module shift_taps_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  output logic [W-1:0]  o_data,
  output logic          o_valid,
  output logic          o_full,
  output logic [CW-1:0] o_count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_do_pop;
  logic w_do_push;

  assign o_valid   = (r_count != '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign o_data    = o_valid ? r_mem[r_rd_ptr] : '0;
  assign w_do_pop  = i_pop && o_valid;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/shift_taps_filter.sv
// Weighted 4-tap filter fed by a tapped shift register.
// One cycle after each shift strobe the four tap values (post-shift contents)
// enter a 3-stage pipeline: products, pairwise sums, total + round + shift +
// saturate. Results queue in an output FIFO; stall throttles the shift strobe
// so that everything in flight always fits in that FIFO.
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush               : synchronous clear of fill count, pipeline, FIFO, overflow
//   shift               : shift strobe (same one the shift register sees)
//   tap_one..sr_out     : 8-bit tap values
//   stall               : upstream must hold shift low while this is high
//   out_data, out_valid : filtered sample and its valid flag
//   out_ready           : consumer ready
//   overflow            : sticky, a finished sample was dropped
//
// Output handshake: a sample transfers on every rising edge where out_valid
// and out_ready are both high. out_valid never depends on out_ready, and
// out_data is held stable while out_valid is high and out_ready is low.
module shift_taps_filter
  import shift_taps_pkg::*;
#(
  parameter int    SR_DEPTH   = 64,
  parameter coef_t COEF0      = 9'sd1,
  parameter coef_t COEF1      = 9'sd1,
  parameter coef_t COEF2      = 9'sd1,
  parameter coef_t COEF3      = 9'sd1,
  parameter int    OUT_SHIFT  = 2,
  parameter int    FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             shift,
  input  logic [TAP_W-1:0] tap_one,
  input  logic [TAP_W-1:0] tap_two,
  input  logic [TAP_W-1:0] tap_three,
  input  logic [TAP_W-1:0] sr_out,
  output logic             stall,
  output logic [TAP_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow
);

  localparam int FILL_W = $clog2(SR_DEPTH + 1);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int OCC_W  = CNT_W + 1;

  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(SR_DEPTH);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(SR_DEPTH - 1);
  localparam logic [OCC_W-1:0]  STALL_AT  = OCC_W'(FIFO_DEPTH - 1);
  // Half an LSB of the shifted result; zero when no shift is applied.
  localparam sum_t              ROUND     = sum_t'((2 ** OUT_SHIFT) / 2);

  logic              r_shift_q;
  logic [FILL_W-1:0] r_fill_cnt;
  logic              r_s1_v;
  logic              r_s2_v;
  logic              r_s3_v;
  logic              r_overflow;
  prod_t             r_p0, r_p1, r_p2, r_p3;
  pair_t             r_pa, r_pb;
  logic [TAP_W-1:0]  r_s3_data;

  logic              w_keep;
  sum_t              w_total;
  sum_t              w_rounded;
  sum_t              w_shifted;
  logic              w_fifo_full;
  logic [CNT_W-1:0]  w_fifo_count;
  logic              w_pop;
  logic              w_drop;
  logic [OCC_W-1:0]  w_occ;

  // The sample captured on this edge counts as shift number fill_cnt+1; the
  // window is complete once that reaches SR_DEPTH, so the SR_DEPTH-th shift
  // is the first one that produces an output.
  assign w_keep = r_shift_q && (r_fill_cnt >= FILL_LAST);

  assign w_total   = sum_t'(r_pa) + sum_t'(r_pb);
  assign w_rounded = w_total + ROUND;
  assign w_shifted = w_rounded >>> OUT_SHIFT;

  assign w_pop  = out_valid && out_ready;
  assign w_drop = r_s3_v && w_fifo_full && !w_pop;

  // Everything already committed to land in the FIFO, including the strobe
  // that is about to be sampled as shift_q.
  assign w_occ = OCC_W'(w_fifo_count) + OCC_W'(r_shift_q) + OCC_W'(r_s1_v)
               + OCC_W'(r_s2_v) + OCC_W'(r_s3_v);
  assign stall    = (w_occ >= STALL_AT);
  assign overflow = r_overflow;

  // Control: strobe delay, fill count, stage valids, sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift_q  <= 1'b0;
      r_fill_cnt <= '0;
      r_s1_v     <= 1'b0;
      r_s2_v     <= 1'b0;
      r_s3_v     <= 1'b0;
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_shift_q  <= 1'b0;
      r_fill_cnt <= '0;
      r_s1_v     <= 1'b0;
      r_s2_v     <= 1'b0;
      r_s3_v     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_shift_q <= shift;
      r_s1_v    <= w_keep;
      r_s2_v    <= r_s1_v;
      r_s3_v    <= r_s2_v;
      if (r_shift_q && (r_fill_cnt != FILL_MAX))
        r_fill_cnt <= r_fill_cnt + 1'b1;
      if (w_drop)
        r_overflow <= 1'b1;
    end
  end

  // Datapath: each stage loads only when the stage before it holds a sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p0      <= '0;
      r_p1      <= '0;
      r_p2      <= '0;
      r_p3      <= '0;
      r_pa      <= '0;
      r_pb      <= '0;
      r_s3_data <= '0;
    end else begin
      if (r_shift_q) begin
        r_p0 <= prod_t'($signed({1'b0, tap_one}))   * prod_t'(COEF0);
        r_p1 <= prod_t'($signed({1'b0, tap_two}))   * prod_t'(COEF1);
        r_p2 <= prod_t'($signed({1'b0, tap_three})) * prod_t'(COEF2);
        r_p3 <= prod_t'($signed({1'b0, sr_out}))    * prod_t'(COEF3);
      end
      if (r_s1_v) begin
        r_pa <= pair_t'(r_p0) + pair_t'(r_p1);
        r_pb <= pair_t'(r_p2) + pair_t'(r_p3);
      end
      if (r_s2_v)
        r_s3_data <= sat_u8(w_shifted);
    end
  end

  shift_taps_fifo #(
    .W     (TAP_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_flush (flush),
    .i_push  (r_s3_v),
    .i_data  (r_s3_data),
    .i_pop   (w_pop),
    .o_data  (out_data),
    .o_valid (out_valid),
    .o_full  (w_fifo_full),
    .o_count (w_fifo_count)
  );

endmodule
